// File: rtl/seq_signed_divider.sv
// seq_signed_divider: signed radix-2 restoring divider, 2W-bit dividend by W-bit
// divisor, one quotient bit per cycle, valid/ready handshake on both sides.
module seq_signed_divider #(
  parameter int WIDTH_DATA = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*WIDTH_DATA-1:0] dividend,
  input  logic [WIDTH_DATA-1:0]   divisor,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*WIDTH_DATA-1:0] quotient,
  output logic [WIDTH_DATA-1:0]   remainder,
  output logic                    div_by_zero,
  output logic                    overflow
);
  localparam int W  = WIDTH_DATA;
  localparam int DW = 2 * WIDTH_DATA;
  localparam int CW = $clog2(DW);
  localparam logic [DW-1:0] Q_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] Q_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DW-1:0] r_dvd;      // dividend magnitude; quotient bits shift in at the LSB
  logic [W:0]    r_dsr;
  logic [W:0]    r_rem;
  logic [CW-1:0] r_cnt;
  logic          r_neg_q;
  logic          r_neg_r;
  logic          r_dbz;
  logic          r_ovf;
  logic [DW-1:0] r_quotient;
  logic [W-1:0]  r_remainder;
  logic          r_div_by_zero;
  logic          r_overflow;

  logic [DW-1:0] w_dvd_mag;
  logic [W:0]    w_dsr_mag;
  logic [W:0]    w_rem_sh;
  logic          w_ge;
  logic [W:0]    w_rem_nx;

  assign w_dvd_mag = dividend[DW-1] ? ({DW{1'b0}} - dividend) : dividend;
  assign w_dsr_mag = divisor[W-1] ? ({(W+1){1'b0}} - {divisor[W-1], divisor})
                                  : {1'b0, divisor};

  // r_rem[W] is the bit shifted out; if ever set the shifted value exceeds any divisor
  assign w_rem_sh = {r_rem[W-1:0], r_dvd[DW-1]};
  assign w_ge     = r_rem[W] | (w_rem_sh >= r_dsr);
  assign w_rem_nx = w_ge ? (w_rem_sh - r_dsr) : w_rem_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)     w_next = S_CALC;
      S_CALC:  if (r_cnt == '0)  w_next = S_FIX;
      S_FIX:                     w_next = S_DONE;
      S_DONE:  if (out_ready)    w_next = S_IDLE;
      default:                   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd         <= '0;
      r_dsr         <= '0;
      r_rem         <= '0;
      r_cnt         <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_dbz         <= 1'b0;
      r_ovf         <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_dvd   <= w_dvd_mag;
          r_dsr   <= w_dsr_mag;
          r_rem   <= '0;
          r_cnt   <= CW'(DW - 1);
          r_neg_q <= dividend[DW-1] ^ divisor[W-1];
          r_neg_r <= dividend[DW-1];
          r_dbz   <= (divisor == '0);
          r_ovf   <= (dividend == Q_MIN) && (divisor == {W{1'b1}});
        end
        S_CALC: begin
          r_rem <= w_rem_nx;
          r_dvd <= {r_dvd[DW-2:0], w_ge};
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          if (r_dbz) begin
            r_quotient    <= r_neg_r ? Q_MIN : Q_MAX;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b1;
            r_overflow    <= 1'b0;
          end else if (r_ovf) begin
            r_quotient    <= Q_MAX;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b1;
          end else begin
            r_quotient    <= r_neg_q ? ({DW{1'b0}} - r_dvd) : r_dvd;
            r_remainder   <= r_neg_r ? ({W{1'b0}} - r_rem[W-1:0]) : r_rem[W-1:0];
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Bench for seq_signed_divider (W=8): integer-arithmetic reference model with an
// expectation queue, a per-cycle output checker, directed corners and random ops.
module tb_seq_signed_divider;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        overflow;

  seq_signed_divider #(.WIDTH_DATA(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int q;
    int r;
    int dz;
    int ov;
    int acc;
  } exp_t;

  exp_t eq[$];
  int   acc_hist[$];
  int   cyc = 0;
  bit   prev_ov = 0;
  bit   rand_rdy = 0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: plain signed integer division with the two saturating overrides
  function automatic void model(input int a, input int b, output int q, output int r,
                                output int dz, output int ov);
    dz = 0; ov = 0;
    if (b == 0) begin
      q = (a >= 0) ? 32767 : -32768; r = 0; dz = 1;
    end else if (a == -32768 && b == -1) begin
      q = 32767; r = 0; ov = 1;
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Per-cycle output checker against the model queue
  exp_t mon_e;
  int   mon_a, mon_b;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      eq.delete();
      prev_ov = 0;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
    end else begin
      if (out_valid) begin
        if (eq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          mon_e = eq[0];
          if (!prev_ov) chk("latency", cyc - mon_e.acc, 18);
          chk("quotient", int'($signed(quotient)), mon_e.q);
          chk("remainder", int'($signed(remainder)), mon_e.r);
          chk("div_by_zero", int'(div_by_zero), mon_e.dz);
          chk("overflow", int'(overflow), mon_e.ov);
          chk("busy_in_ready", int'(in_ready), 0);
          if (out_ready) void'(eq.pop_front());
        end
      end
      prev_ov = out_valid;
      if (in_valid && in_ready) begin
        mon_a = int'($signed(dividend));
        mon_b = int'($signed(divisor));
        model(mon_a, mon_b, mon_e.q, mon_e.r, mon_e.dz, mon_e.ov);
        mon_e.acc = cyc;
        eq.push_back(mon_e);
        acc_hist.push_back(cyc);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Called aligned just after a rising edge; returns just after the accept edge.
  task automatic send(input int a, input int b, input bit hold);
    int n;
    n = 0;
    dividend = a[15:0];
    divisor  = b[7:0];
    in_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!in_ready && n < 200);
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_out(output int q, output int r, output int dz, output int ov);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 200);
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL result_timeout: got out_valid=0 expected 1 within 200 cycles");
    end
    q  = int'($signed(quotient));
    r  = int'($signed(remainder));
    dz = int'(div_by_zero);
    ov = int'(overflow);
    @(posedge clk); #1;
  endtask

  task automatic dir(input string nm, input int a, input int b,
                     input int eqv, input int erv, input int edz, input int eov);
    int q, r, dz, ov;
    send(a, b, 1'b0);
    wait_out(q, r, dz, ov);
    chk({nm, "_q"}, q, eqv);
    chk({nm, "_r"}, r, erv);
    chk({nm, "_dz"}, dz, edz);
    chk({nm, "_ov"}, ov, eov);
  endtask

  initial begin
    int q, r, dz, ov, n0, n;
    int hq, hr;
    int a, b, sel;

    rst_n = 1'b0; in_valid = 1'b0; dividend = '0; divisor = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    chk("rst_ovf", int'(overflow), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Pin the reference model to hand-computed values
    model(1000, 7, q, r, dz, ov);      chk("pin_1000_7_q", q, 142);  chk("pin_1000_7_r", r, 6);
    model(-1000, 7, q, r, dz, ov);     chk("pin_m1000_7_r", r, -6);
    model(12345, -128, q, r, dz, ov);  chk("pin_12345_q", q, -96);   chk("pin_12345_r", r, 57);
    model(-5, 0, q, r, dz, ov);        chk("pin_m5_0_q", q, -32768); chk("pin_m5_0_dz", dz, 1);
    model(-32768, -1, q, r, dz, ov);   chk("pin_ovf_q", q, 32767);   chk("pin_ovf_ov", ov, 1);

    dir("p1000_p7",   1000,   7,    142,    6, 0, 0);
    dir("m1000_p7",  -1000,   7,   -142,   -6, 0, 0);
    dir("p1000_m7",   1000,  -7,   -142,    6, 0, 0);
    dir("m1000_m7",  -1000,  -7,    142,   -6, 0, 0);
    dir("p1000_z",    1000,   0,  32767,    0, 1, 0);
    dir("m5_z",         -5,   0, -32768,    0, 1, 0);
    dir("min_m1",   -32768,  -1,  32767,    0, 0, 1);
    dir("p12345_m128", 12345, -128,  -96,   57, 0, 0);
    dir("flags_clear",  7,    7,      1,    0, 0, 0);

    // Backpressure: outputs held, no new accept
    out_ready = 1'b0;
    send(-1000, 7, 1'b0);
    wait_out(hq, hr, dz, ov);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_q", int'($signed(quotient)), hq);
      chk("hold_r", int'($signed(remainder)), hr);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;

    // Back-to-back with the request held high
    n0 = acc_hist.size();
    send(30000, 99, 1'b1);
    send(-12345, 57, 1'b0);
    wait_out(q, r, dz, ov);
    chk("b2b_q", q, -216);
    chk("b2b_r", r, -33);
    if (acc_hist.size() >= n0 + 2) chk("b2b_period", acc_hist[n0+1] - acc_hist[n0], 19);
    else begin
      checks++; errors++;
      $display("FAIL b2b_accepts: got %0d expected %0d", acc_hist.size() - n0, 2);
    end

    // Reset during CALC discards the operation
    send(500, 9, 1'b0);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    dir("after_rst", 100, 3, 33, 1, 0, 0);

    // Random operands with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      sel = int'($urandom_range(0, 9));
      a = int'($signed(16'($urandom)));
      b = int'($signed(8'($urandom)));
      case (sel)
        0: b = 0;
        1: begin a = -32768; b = -1; end
        2: b = -128;
        3: a = -32768;
        4: b = 1;
        default: ;
      endcase
      send(a, b, 1'b0);
    end
    n = 0;
    while (eq.size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (eq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", eq.size());
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
